// File: rtl/qix_video_mixer.sv
`default_nettype none
// qix_video_mixer: Qix RRGGBBII palette lookup, monitor mix modes, 3-cycle sync/blank delay.
// Option macro QIX_MONO_MODES_EN builds the luminance mix modes (green/amber/cyan/gray). Rev 1.0
module qix_video_mixer #(
  parameter  int PIX_W     = 8,
  parameter  int PAL_BANKS = 4,
  localparam int BANK_W    = (PAL_BANKS > 1) ? $clog2(PAL_BANKS) : 1,
  localparam int ADDR_W    = BANK_W + PIX_W
) (
  input  logic              clk_vid,
  input  logic              reset_n,
  input  logic [PIX_W-1:0]  i_Pixel,
  input  logic [BANK_W-1:0] i_Bank,
  input  logic              i_HSync,
  input  logic              i_VSync,
  input  logic              i_HBlank,
  input  logic              i_VBlank,
  input  logic [2:0]        i_Mix,
  input  logic [ADDR_W-1:0] i_PalAddr,
  input  logic [7:0]        i_PalData,
  input  logic              i_PalWr,
  output logic              o_PalBusy,
  output logic              o_PalOvf,
  output logic [3:0]        o_R,
  output logic [3:0]        o_G,
  output logic [3:0]        o_B,
  output logic              o_HSync,
  output logic              o_VSync,
  output logic              o_HBlank,
  output logic              o_VBlank
);

  typedef enum logic [0:0] {
    PAL_IDLE = 1'b0,
    PAL_PEND = 1'b1
  } pal_state_t;

  // Timing vectors are packed {hsync, vsync, hblank, vblank}.
  logic [PIX_W-1:0]  pix_s0_d,  pix_s0_q;
  logic [BANK_W-1:0] bank_s0_d, bank_s0_q;
  logic [3:0]        tim_s0_d,  tim_s0_q;
  logic [3:0]        tim_s1_d,  tim_s1_q;
  logic [3:0]        tim_s2_d,  tim_s2_q;
  logic [7:0]        rd_d,      rd_q;
  logic [11:0]       rgb_d,     rgb_q;

  pal_state_t        pal_state_d, pal_state_q;
  logic [ADDR_W-1:0] pal_addr_d,  pal_addr_q;
  logic [7:0]        pal_data_d,  pal_data_q;
  logic              pal_ovf_d,   pal_ovf_q;
  logic              pal_commit;
  logic              blank_s0;

  logic [7:0]        pal_ram [0:(1<<ADDR_W)-1];

  logic [3:0]        chan_r, chan_g, chan_b;

`ifdef QIX_MONO_MODES_EN
  logic [2:0]        mix_s0_d, mix_s0_q;
  logic [2:0]        mix_s1_d, mix_s1_q;
  logic [5:0]        lum_sum;
  logic [3:0]        lum;
`else
  logic              unused_mix;
  assign unused_mix = ^i_Mix;
`endif

  assign blank_s0 = tim_s0_q[1] | tim_s0_q[0];

  // Pipeline next-state: S0 capture, S1 palette read, S2 timing follow.
  always_comb begin
    pix_s0_d  = i_Pixel;
    bank_s0_d = i_Bank;
    tim_s0_d  = {i_HSync, i_VSync, i_HBlank, i_VBlank};
    rd_d      = pal_ram[{bank_s0_q, pix_s0_q}];
    tim_s1_d  = tim_s0_q;
    tim_s2_d  = tim_s1_q;
`ifdef QIX_MONO_MODES_EN
    mix_s0_d  = i_Mix;
    mix_s1_d  = mix_s0_q;
`endif
  end

  // Colour stage: RRGGBBII -> {cc, ii} per channel, then mix and blank.
  always_comb begin
    chan_r = {rd_q[7:6], rd_q[1:0]};
    chan_g = {rd_q[5:4], rd_q[1:0]};
    chan_b = {rd_q[3:2], rd_q[1:0]};
    rgb_d  = {chan_r, chan_g, chan_b};
`ifdef QIX_MONO_MODES_EN
    lum_sum = {2'b00, chan_r} + {1'b0, chan_g, 1'b0} + {2'b00, chan_b};
    lum     = lum_sum[5:2];
    case (mix_s1_q)
      3'd2:    rgb_d = {4'h0, lum, 4'h0};
      3'd3:    rgb_d = {lum, lum - {2'b00, lum[3:2]}, 4'h0};
      3'd4:    rgb_d = {4'h0, lum, lum};
      3'd5:    rgb_d = {lum, lum, lum};
      default: rgb_d = {chan_r, chan_g, chan_b};
    endcase
`endif
    if (tim_s1_q[1] | tim_s1_q[0]) begin
      rgb_d = 12'h000;
    end
  end

  // Write buffer: holds one entry and commits only while S0 is blanked,
  // so the shared RAM port never disturbs a visible pixel.
  always_comb begin
    pal_state_d = pal_state_q;
    pal_addr_d  = pal_addr_q;
    pal_data_d  = pal_data_q;
    pal_ovf_d   = pal_ovf_q;
    pal_commit  = 1'b0;
    case (pal_state_q)
      PAL_IDLE: begin
        if (i_PalWr) begin
          pal_addr_d  = i_PalAddr;
          pal_data_d  = i_PalData;
          pal_state_d = PAL_PEND;
        end
      end
      PAL_PEND: begin
        if (i_PalWr) begin
          pal_ovf_d = 1'b1;
        end
        if (blank_s0) begin
          pal_commit  = 1'b1;
          pal_state_d = PAL_IDLE;
        end
      end
      default: pal_state_d = PAL_IDLE;
    endcase
  end

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      pix_s0_q    <= '0;
      bank_s0_q   <= '0;
      tim_s0_q    <= '0;
      tim_s1_q    <= '0;
      tim_s2_q    <= '0;
      rd_q        <= '0;
      rgb_q       <= '0;
      pal_state_q <= PAL_IDLE;
      pal_addr_q  <= '0;
      pal_data_q  <= '0;
      pal_ovf_q   <= 1'b0;
`ifdef QIX_MONO_MODES_EN
      mix_s0_q    <= '0;
      mix_s1_q    <= '0;
`endif
    end else begin
      pix_s0_q    <= pix_s0_d;
      bank_s0_q   <= bank_s0_d;
      tim_s0_q    <= tim_s0_d;
      tim_s1_q    <= tim_s1_d;
      tim_s2_q    <= tim_s2_d;
      rd_q        <= rd_d;
      rgb_q       <= rgb_d;
      pal_state_q <= pal_state_d;
      pal_addr_q  <= pal_addr_d;
      pal_data_q  <= pal_data_d;
      pal_ovf_q   <= pal_ovf_d;
`ifdef QIX_MONO_MODES_EN
      mix_s0_q    <= mix_s0_d;
      mix_s1_q    <= mix_s1_d;
`endif
    end
  end

  // Palette contents survive reset.
  always_ff @(posedge clk_vid) begin
    if (pal_commit) begin
      pal_ram[pal_addr_q] <= pal_data_q;
    end
  end

  assign o_PalBusy = (pal_state_q == PAL_PEND);
  assign o_PalOvf  = pal_ovf_q;
  assign o_R       = rgb_q[11:8];
  assign o_G       = rgb_q[7:4];
  assign o_B       = rgb_q[3:0];
  assign o_HSync   = tim_s2_q[3];
  assign o_VSync   = tim_s2_q[2];
  assign o_HBlank  = tim_s2_q[1];
  assign o_VBlank  = tim_s2_q[0];

endmodule
`default_nettype wire

// File: tb/tb_qix_video_mixer.sv
`default_nettype none
// tb_qix_video_mixer: directed self-checking bench for qix_video_mixer.
// Expected colours are hand-derived from the RRGGBBII entries written by the bench. Rev 1.0
module tb_qix_video_mixer;

  logic        clk_vid;
  logic        reset_n;
  logic [7:0]  i_Pixel;
  logic [1:0]  i_Bank;
  logic        i_HSync, i_VSync, i_HBlank, i_VBlank;
  logic [2:0]  i_Mix;
  logic [9:0]  i_PalAddr;
  logic [7:0]  i_PalData;
  logic        i_PalWr;
  logic        o_PalBusy, o_PalOvf;
  logic [3:0]  o_R, o_G, o_B;
  logic        o_HSync, o_VSync, o_HBlank, o_VBlank;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef QIX_MONO_MODES_EN
  localparam logic [11:0] EXP_M2 = 12'h070;
  localparam logic [11:0] EXP_M3 = 12'h760;
  localparam logic [11:0] EXP_M4 = 12'h077;
  localparam logic [11:0] EXP_M5 = 12'h777;
`else
  localparam logic [11:0] EXP_M2 = 12'hE62;
  localparam logic [11:0] EXP_M3 = 12'hE62;
  localparam logic [11:0] EXP_M4 = 12'hE62;
  localparam logic [11:0] EXP_M5 = 12'hE62;
`endif

  qix_video_mixer dut (
    .clk_vid   (clk_vid),
    .reset_n   (reset_n),
    .i_Pixel   (i_Pixel),
    .i_Bank    (i_Bank),
    .i_HSync   (i_HSync),
    .i_VSync   (i_VSync),
    .i_HBlank  (i_HBlank),
    .i_VBlank  (i_VBlank),
    .i_Mix     (i_Mix),
    .i_PalAddr (i_PalAddr),
    .i_PalData (i_PalData),
    .i_PalWr   (i_PalWr),
    .o_PalBusy (o_PalBusy),
    .o_PalOvf  (o_PalOvf),
    .o_R       (o_R),
    .o_G       (o_G),
    .o_B       (o_B),
    .o_HSync   (o_HSync),
    .o_VSync   (o_VSync),
    .o_HBlank  (o_HBlank),
    .o_VBlank  (o_VBlank)
  );

  initial begin
    clk_vid = 1'b0;
    forever #5 clk_vid = ~clk_vid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_vid);
    #1;
  endtask

  function automatic logic [11:0] rgb();
    return {o_R, o_G, o_B};
  endfunction

  logic [3:0]  pat [16];
  logic [2:0]  mix_modes [7];
  logic [11:0] mix_exp [7];

  initial begin
    pat = '{4'b1000, 4'b0000, 4'b1010, 4'b0001, 4'b0000, 4'b1000, 4'b0100, 4'b0000,
            4'b0011, 4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b1001, 4'b0000, 4'b0000};
    mix_modes = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    mix_exp   = '{EXP_M2, EXP_M3, EXP_M4, EXP_M5, 12'hE62, 12'hE62, 12'hE62};

    // Reset held with busy inputs.
    reset_n   = 1'b0;
    i_Pixel   = 8'hA5;
    i_Bank    = 2'd3;
    i_HSync   = 1'b1;
    i_VSync   = 1'b1;
    i_HBlank  = 1'b1;
    i_VBlank  = 1'b0;
    i_Mix     = 3'd5;
    i_PalAddr = 10'h3FF;
    i_PalData = 8'hFF;
    i_PalWr   = 1'b1;
    repeat (5) step();
    check("rst_rgb",  32'(rgb()), 32'h0);
    check("rst_sync", 32'({o_HSync, o_VSync, o_HBlank, o_VBlank}), 32'h0);
    check("rst_busy", 32'(o_PalBusy), 32'h0);
    check("rst_ovf",  32'(o_PalOvf), 32'h0);

    reset_n  = 1'b1;
    i_PalWr  = 1'b0;
    i_HSync  = 1'b0;
    i_VSync  = 1'b0;
    i_HBlank = 1'b1;
    repeat (3) step();

    // Write during blank commits on the next cycle.
    i_PalAddr = {2'd1, 8'h05};
    i_PalData = 8'hD2;
    i_PalWr   = 1'b1;
    step();
    i_PalWr = 1'b0;
    check("wr_busy_hi", 32'(o_PalBusy), 32'h1);
    step();
    check("wr_busy_lo", 32'(o_PalBusy), 32'h0);

    // Read back; the pixel sampled at the next edge appears 3 edges later.
    i_HBlank = 1'b0;
    i_Bank   = 2'd1;
    i_Pixel  = 8'h05;
    i_Mix    = 3'd0;
    step();
    step();
    check("lat_pre", 32'(rgb()), 32'h0);
    step();
    check("rw_rgb", 32'(rgb()), 32'hE62);

    for (int m = 0; m < 7; m++) begin
      i_Mix = mix_modes[m];
      repeat (3) step();
      check($sformatf("mix%0d", mix_modes[m]), 32'(rgb()), 32'(mix_exp[m]));
    end

    // Deferred commit during active video, plus an overflow write.
    i_PalAddr = {2'd2, 8'h33};
    i_PalData = 8'h5A;
    i_PalWr   = 1'b1;
    step();
    i_PalWr = 1'b0;
    check("def_busy0", 32'(o_PalBusy), 32'h1);
    repeat (3) step();
    check("def_busy1", 32'(o_PalBusy), 32'h1);
    i_PalData = 8'hFF;
    i_PalWr   = 1'b1;
    step();
    i_PalWr = 1'b0;
    check("ovf_set",   32'(o_PalOvf), 32'h1);
    check("ovf_busy",  32'(o_PalBusy), 32'h1);
    i_HBlank = 1'b1;
    step();
    check("def_busy2", 32'(o_PalBusy), 32'h1);
    step();
    check("def_done",  32'(o_PalBusy), 32'h0);
    i_HBlank = 1'b0;
    i_Bank   = 2'd2;
    i_Pixel  = 8'h33;
    i_Mix    = 3'd0;
    repeat (3) step();
    check("def_rgb",    32'(rgb()), 32'h66A);
    check("ovf_sticky", 32'(o_PalOvf), 32'h1);

    // Timing pulse train: outputs are the input delayed by 3 edges.
    i_Bank  = 2'd1;
    i_Pixel = 8'h05;
    for (int j = 0; j < 16; j++) begin
      {i_HSync, i_VSync, i_HBlank, i_VBlank} = pat[j];
      step();
      if (j >= 2) begin
        check($sformatf("dly_t%0d", j), 32'({o_HSync, o_VSync, o_HBlank, o_VBlank}),
              32'(pat[j-2]));
        check($sformatf("dly_rgb%0d", j), 32'(rgb()),
              (pat[j-2][1] | pat[j-2][0]) ? 32'h0 : 32'hE62);
      end
    end
    {i_HSync, i_VSync, i_HBlank, i_VBlank} = 4'b0000;
    repeat (3) step();

    // Reset while a write is pending: busy drops immediately, RAM untouched.
    i_PalAddr = {2'd1, 8'h05};
    i_PalData = 8'h00;
    i_PalWr   = 1'b1;
    step();
    i_PalWr = 1'b0;
    check("pend_busy", 32'(o_PalBusy), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(o_PalBusy), 32'h0);
    check("arst_ovf",  32'(o_PalOvf), 32'h0);
    check("arst_rgb",  32'(rgb()), 32'h0);
    i_HBlank = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();
    i_HBlank = 1'b0;
    i_Bank   = 2'd1;
    i_Pixel  = 8'h05;
    i_Mix    = 3'd0;
    repeat (3) step();
    check("arst_ram", 32'(rgb()), 32'hE62);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
